// File: rtl/xlink_tx_arbiter.sv
// xlink_tx_arbiter: packet-level round-robin arbiter that shares one XLink
// tx token port between NREQ producers; the grant is held until END/PAUSE.
// Ports:
//   clk, reset          clock, async active-high reset
//   req_token_in        9-bit token of requester i on [9i+8:9i]
//   req_valid           requester i presents a token
//   req_taken           one-hot accept of the granted requester's token
//   tx_token_out/valid  forwarded token to the tx buffer
//   tx_token_taken      tx buffer accepts the token
//   grant_id            current/last granted requester
//   busy                packet in progress
//   timeout_err         sticky watchdog error (XLINK_ARB_TIMEOUT_EN only)
// Option: define XLINK_ARB_TIMEOUT_EN to enable the stall watchdog, which
// closes a stalled packet with a forced END token.
module xlink_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9*NREQ-1:0] req_token_in,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_taken,
  output logic [8:0]        tx_token_out,
  output logic              tx_token_valid,
  input  logic              tx_token_taken,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              timeout_err
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_chk
    $error("xlink_tx_arbiter: parameter out of range");
  end

`ifdef XLINK_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, FWD, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, FWD} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] last_q;
  logic [2:0] pick;
  logic       any_v;
  logic [8:0] g_tok;
  logic       g_vld;
  logic       term;
  logic       fwd_xfer;

  // Round-robin pick: smallest rotation distance after last_q wins.
  always_comb begin
    int best;
    int d;
    best = NREQ;
    pick = last_q;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(last_q)) % NREQ;
      if (req_valid[i] && d < best) begin
        best = d;
        pick = 3'(i);
      end
    end
  end

  assign any_v = |req_valid;

  // Granted requester's token/valid.
  always_comb begin
    g_tok = '0;
    g_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 3'(i)) begin
        g_tok = req_token_in[9*i +: 9];
        g_vld = req_valid[i];
      end
    end
  end

  assign term     = (g_tok == 9'h101) || (g_tok == 9'h102);
  assign fwd_xfer = g_vld && tx_token_taken;
  assign busy     = (state_q != IDLE);

`ifdef XLINK_ARB_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        terr_q;
  logic        wd_hit;

  assign wd_hit      = (wd_q + 16'd1) == 16'(TIMEOUT);
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    tx_token_out   = '0;
    tx_token_valid = 1'b0;
    req_taken      = '0;
    unique case (state_q)
      IDLE: begin
        if (any_v) state_d = FWD;
      end
      FWD: begin
        tx_token_out   = g_tok;
        tx_token_valid = g_vld;
        for (int i = 0; i < NREQ; i++)
          req_taken[i] = (grant_id == 3'(i)) && fwd_xfer;
        if (fwd_xfer && term) state_d = IDLE;
`ifdef XLINK_ARB_TIMEOUT_EN
        else if (!g_vld && wd_hit) state_d = FLUSH;
`endif
      end
`ifdef XLINK_ARB_TIMEOUT_EN
      FLUSH: begin
        tx_token_out   = 9'h101;
        tx_token_valid = 1'b1;
        if (tx_token_taken) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id <= '0;
      last_q   <= 3'(NREQ - 1);
    end else begin
      if (state_q == IDLE && any_v)
        grant_id <= pick;
      if (state_q == FWD && fwd_xfer && term)
        last_q <= grant_id;
`ifdef XLINK_ARB_TIMEOUT_EN
      if (state_q == FLUSH && tx_token_taken)
        last_q <= grant_id;
`endif
    end
  end

`ifdef XLINK_ARB_TIMEOUT_EN
  // Watchdog counts only granted-idle FWD cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == FWD && !g_vld) wd_q <= wd_q + 16'd1;
      else                          wd_q <= '0;
      if (state_q == FLUSH && tx_token_taken)
        terr_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xlink_tx_arbiter.sv
// tb_xlink_tx_arbiter: table-driven directed bench for xlink_tx_arbiter
// (NREQ=4), plus hand sequences for async reset and the watchdog.
module tb_xlink_tx_arbiter;

  localparam int NREQ = 4;
`ifdef XLINK_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [9*NREQ-1:0] req_token_in;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_taken;
  logic [8:0]        tx_token_out;
  logic              tx_token_valid;
  logic              tx_token_taken;
  logic [2:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  xlink_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_token_in   (req_token_in),
    .req_valid      (req_valid),
    .req_taken      (req_taken),
    .tx_token_out   (tx_token_out),
    .tx_token_valid (tx_token_valid),
    .tx_token_taken (tx_token_taken),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [35:0] tok;
    logic        tk;
    logic        ev;
    logic [8:0]  et;
    logic [3:0]  eq;
    logic        eb;
    logic [2:0]  eg;
    logic        ee;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   nb;

  function automatic vec_t mk(
    logic [3:0] v, logic [8:0] t0, logic [8:0] t1,
    logic [8:0] t2, logic [8:0] t3, logic tk,
    logic ev, logic [8:0] et, logic [3:0] eq,
    logic eb, logic [2:0] eg, logic ee);
    vec_t x;
    x.v = v; x.tok = {t3, t2, t1, t0}; x.tk = tk;
    x.ev = ev; x.et = et; x.eq = eq;
    x.eb = eb; x.eg = eg; x.ee = ee;
    return x;
  endfunction

  function automatic void add(
    logic [3:0] v, logic [8:0] t0, logic [8:0] t1,
    logic [8:0] t2, logic [8:0] t3, logic tk,
    logic ev, logic [8:0] et, logic [3:0] eq,
    logic eb, logic [2:0] eg, logic ee);
    tbl.push_back(mk(v, t0, t1, t2, t3, tk, ev, et, eq, eb, eg, ee));
  endfunction

  task automatic drive(input vec_t x);
    req_valid      = x.v;
    req_token_in   = x.tok;
    tx_token_taken = x.tk;
  endtask

  task automatic check(input string nm, input logic [18:0] exp);
    logic [18:0] act;
    act = {tx_token_valid, tx_token_out, req_taken,
           busy, grant_id, timeout_err};
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {v,tok,taken,busy,gid,err}=%h want %h",
                  nm, act, exp);
  endtask

  task automatic step(input vec_t x, input string nm);
    drive(x);
    #3;
    check(nm, {x.ev, x.et, x.eq, x.eb, x.eg, x.ee});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // contention: 0,1,3 together, then 1 alone
    add(4'b1011, 'h010, 'h020, 0, 'h030, 1, 0, 0, 0, 0, 0, 0);
    add(4'b1011, 'h010, 'h020, 0, 'h030, 1, 1, 'h010, 4'b0001, 1, 0, 0);
    add(4'b1011, 'h011, 'h020, 0, 'h030, 1, 1, 'h011, 4'b0001, 1, 0, 0);
    add(4'b1011, 'h101, 'h020, 0, 'h030, 1, 1, 'h101, 4'b0001, 1, 0, 0);
    add(4'b1010, 0, 'h020, 0, 'h030, 1, 0, 0, 0, 0, 0, 0);
    add(4'b1010, 0, 'h020, 0, 'h030, 1, 1, 'h020, 4'b0010, 1, 1, 0);
    add(4'b1010, 0, 'h021, 0, 'h030, 1, 1, 'h021, 4'b0010, 1, 1, 0);
    add(4'b1010, 0, 'h101, 0, 'h030, 1, 1, 'h101, 4'b0010, 1, 1, 0);
    add(4'b1000, 0, 0, 0, 'h030, 1, 0, 0, 0, 0, 1, 0);
    add(4'b1000, 0, 0, 0, 'h030, 1, 1, 'h030, 4'b1000, 1, 3, 0);
    add(4'b1000, 0, 0, 0, 'h031, 1, 1, 'h031, 4'b1000, 1, 3, 0);
    add(4'b1000, 0, 0, 0, 'h101, 1, 1, 'h101, 4'b1000, 1, 3, 0);
    add(4'b0010, 0, 'h040, 0, 0, 1, 0, 0, 0, 0, 3, 0);
    add(4'b0010, 0, 'h040, 0, 0, 1, 1, 'h040, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 'h101, 0, 0, 1, 1, 'h101, 4'b0010, 1, 1, 0);
    // single packet from req 2
    add(4'b0100, 0, 0, 'h000, 0, 1, 0, 0, 0, 0, 1, 0);
    add(4'b0100, 0, 0, 'h000, 0, 1, 1, 'h000, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 0, 'h001, 0, 1, 1, 'h001, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 0, 'h002, 0, 1, 1, 'h002, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 0, 'h055, 0, 1, 1, 'h055, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 0, 'h101, 0, 1, 1, 'h101, 4'b0100, 1, 2, 0);
    // backpressure on req 1
    add(4'b0010, 0, 'h060, 0, 0, 1, 0, 0, 0, 0, 2, 0);
    add(4'b0010, 0, 'h060, 0, 0, 1, 1, 'h060, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 'h061, 0, 0, 0, 1, 'h061, 4'b0000, 1, 1, 0);
    add(4'b0010, 0, 'h061, 0, 0, 0, 1, 'h061, 4'b0000, 1, 1, 0);
    add(4'b0010, 0, 'h061, 0, 0, 1, 1, 'h061, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 'h101, 0, 0, 0, 1, 'h101, 4'b0000, 1, 1, 0);
    add(4'b0010, 0, 'h101, 0, 0, 0, 1, 'h101, 4'b0000, 1, 1, 0);
    add(4'b0010, 0, 'h101, 0, 0, 1, 1, 'h101, 4'b0010, 1, 1, 0);
    // non-terminating control token, valid gap, req 1 waiting
    add(4'b0011, 'h0AA, 'h070, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(4'b0011, 'h0AA, 'h070, 0, 0, 1, 1, 'h0AA, 4'b0001, 1, 0, 0);
    add(4'b0011, 'h103, 'h070, 0, 0, 1, 1, 'h103, 4'b0001, 1, 0, 0);
    add(4'b0010, 'h0BB, 'h070, 0, 0, 1, 0, 'h0BB, 4'b0000, 1, 0, 0);
    add(4'b0011, 'h0BB, 'h070, 0, 0, 1, 1, 'h0BB, 4'b0001, 1, 0, 0);
    add(4'b0011, 'h102, 'h070, 0, 0, 1, 1, 'h102, 4'b0001, 1, 0, 0);
    add(4'b0010, 0, 'h070, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 'h070, 0, 0, 1, 1, 'h070, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 'h101, 0, 0, 1, 1, 'h101, 4'b0010, 1, 1, 0);
    add(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    nb = tbl.size();
`ifdef XLINK_ARB_TIMEOUT_EN
    // watchdog: req 2 stalls after two tokens
    add(4'b0100, 0, 0, 'h0C0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(4'b0100, 0, 0, 'h0C0, 0, 1, 1, 'h0C0, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 0, 'h0C1, 0, 1, 1, 'h0C1, 4'b0100, 1, 2, 0);
    for (int i = 0; i < 8; i++)
      add(4'b0000, 0, 0, 'h0C1, 0, 1, 0, 'h0C1, 4'b0000, 1, 2, 0);
    add(4'b0000, 0, 0, 'h0C1, 0, 0, 1, 'h101, 4'b0000, 1, 2, 0);
    add(4'b0000, 0, 0, 'h0C1, 0, 1, 1, 'h101, 4'b0000, 1, 2, 0);
    add(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1);
    add(4'b0100, 0, 0, 'h0D0, 0, 1, 0, 0, 0, 0, 2, 1);
    add(4'b0100, 0, 0, 'h0D0, 0, 1, 1, 'h0D0, 4'b0100, 1, 2, 1);
`endif

    // reset state, with requests present
    reset = 1'b1;
    drive(mk(4'b1111, 'h1AA, 'h055, 'h101, 'h0FF, 1,
             0, 0, 0, 0, 0, 0));
    #3;
    check("reset_state", 19'h0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < nb; i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // reset mid-packet from req 3
    step(mk(4'b1000, 0, 0, 0, 'h080, 1, 0, 0, 0, 0, 1, 0), "rst_idle");
    step(mk(4'b1000, 0, 0, 0, 'h080, 1, 1, 'h080, 4'b1000, 1, 3, 0),
         "rst_tok0");
    step(mk(4'b1000, 0, 0, 0, 'h081, 1, 1, 'h081, 4'b1000, 1, 3, 0),
         "rst_tok1");
    drive(mk(4'b1001, 'h090, 0, 0, 'h082, 1, 0, 0, 0, 0, 0, 0));
    #3;
    check("rst_pre", {1'b1, 9'h082, 4'b1000, 1'b1, 3'd3, 1'b0});
    reset = 1'b1;
    #1;
    check("rst_async", 19'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(mk(4'b1001, 'h090, 0, 0, 'h082, 1, 0, 0, 0, 0, 0, 0),
         "rst_idle2");
    step(mk(4'b1001, 'h090, 0, 0, 'h082, 1, 1, 'h090, 4'b0001, 1, 0, 0),
         "rst_rr0");

`ifdef XLINK_ARB_TIMEOUT_EN
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = nb; i < tbl.size(); i++)
      step(tbl[i], $sformatf("wd%0d", i - nb));
    reset = 1'b1;
    #1;
    check("terr_clear", 19'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
